// File: rtl/squash_pkg.sv
// Shared constants for the Solo Squash input conditioning slice: channel map and default timing.
// Channel order matches the wrapper io_in[4:0] bit order.
package squash_pkg;

  localparam int N_BTN         = 5;
  localparam int BTN_EXT_RESET = 0;
  localparam int BTN_PAUSE     = 1;
  localparam int BTN_NEW_GAME  = 2;
  localparam int BTN_DOWN      = 3;
  localparam int BTN_UP        = 4;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_DEBOUNCE_BITS = 16;
  localparam int DEF_REPEAT_DELAY  = 8_000_000;
  localparam int DEF_REPEAT_PERIOD = 2_000_000;

  // Only the paddle keys auto-repeat; holding pause/new-game/reset must not retrigger.
  function automatic bit is_repeat_ch(input int ch);
    return (ch == BTN_DOWN) || (ch == BTN_UP);
  endfunction

endpackage

// File: rtl/squash_input_conditioner_channel.sv
// One button channel: sync chain, saturating debounce counter, registered level and press pulse.
// Raw edge to level/press: SYNC_STAGES + 2**DEBOUNCE_BITS cycles; no backpressure, press is a one-shot.
module debounce_channel #(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 16,
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 8_000_000,
  parameter int REPEAT_PERIOD = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level_n,
  output logic press
);

  localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;

  logic [SYNC_STAGES-1:0]   sync;
  logic                     syn;
  logic [DEBOUNCE_BITS-1:0] cnt;
  logic                     flip;
  logic                     fall;
  logic                     rpt_hit;

  assign syn  = sync[SYNC_STAGES-1];
  assign flip = (syn != level_n) && (cnt == DB_MAX);
  assign fall = flip & level_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '1;
      cnt     <= '0;
      level_n <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn_n};
      press <= fall | rpt_hit;
      if (syn == level_n) begin
        cnt <= '0;
      end else if (flip) begin
        level_n <= syn;
        cnt     <= '0;
      end else begin
        cnt <= cnt + DEBOUNCE_BITS'(1);
      end
    end
  end

  generate
    if (REPEAT_EN && (REPEAT_PERIOD > 0) && (REPEAT_DELAY >= REPEAT_PERIOD)) begin : g_rpt
      localparam int RPT_W = $clog2(REPEAT_DELAY) + 1;
      localparam logic [RPT_W-1:0] RPT_HIT    = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

      logic [RPT_W-1:0] rpt_cnt;
      logic             rise;

      // A repeat landing on the release edge is suppressed so no pulse accompanies the release.
      assign rise    = flip & ~level_n;
      assign rpt_hit = ~level_n & ~rise & (rpt_cnt == RPT_HIT);

      // Reloading to DELAY-PERIOD makes every later hit land PERIOD cycles apart.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rpt_cnt <= '0;
        end else if (level_n || rise) begin
          rpt_cnt <= '0;
        end else if (rpt_hit) begin
          rpt_cnt <= RPT_RELOAD;
        end else begin
          rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
      end
    end else begin : g_no_rpt
      assign rpt_hit = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/squash_input_conditioner.sv
// Conditions the five raw active-low pads into debounced levels, press pulses and a design reset.
// Levels/press lag the pad by SYNC_STAGES+DB_MAX+1, design_reset lags ext reset by 2; SQUASH_AUTOREPEAT_EN adds up/down repeat.
module squash_input_conditioner #(
  parameter int N_BTN         = squash_pkg::N_BTN,
  parameter int SYNC_STAGES   = squash_pkg::DEF_SYNC_STAGES,
  parameter int DEBOUNCE_BITS = squash_pkg::DEF_DEBOUNCE_BITS,
  parameter int REPEAT_DELAY  = squash_pkg::DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = squash_pkg::DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n_in,
  output logic [N_BTN-1:0] btn_n_out,
  output logic [N_BTN-1:0] press,
  output logic             design_reset
);

  import squash_pkg::*;

`ifdef SQUASH_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic r1;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_BITS(DEBOUNCE_BITS),
        .REPEAT_EN    (AUTOREPEAT && is_repeat_ch(i)),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .btn_n  (btn_n_in[i]),
        .level_n(btn_n_out[i]),
        .press  (press[i])
      );
    end
  endgenerate

  // Asserts immediately on rst, releases two clean clock edges after both sources are inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1           <= 1'b1;
      design_reset <= 1'b1;
    end else begin
      r1           <= ~btn_n_out[BTN_EXT_RESET];
      design_reset <= r1;
    end
  end

endmodule

// File: tb/tb_squash_input_conditioner.sv
// Directed bench for squash_input_conditioner with a press-event scoreboard (DB_MAX=7, repeat 20/5).
// Expected press events are queued when a pad is driven and matched as pulses appear.
module tb_squash_input_conditioner;

  localparam int NB  = 5;
  localparam int LAT = 10;  // SYNC_STAGES + DB_MAX + 1

  typedef struct {
    int            cyc;
    logic [NB-1:0] vec;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn_n_in = '1;
  logic [NB-1:0] btn_n_out;
  logic [NB-1:0] press;
  logic          design_reset;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  squash_input_conditioner #(
    .N_BTN        (NB),
    .SYNC_STAGES  (2),
    .DEBOUNCE_BITS(3),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n_in    (btn_n_in),
    .btn_n_out   (btn_n_out),
    .press       (press),
    .design_reset(design_reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_press(input int at, input logic [NB-1:0] vec);
    exp_t e;
    e.cyc = at;
    e.vec = vec;
    exp_q.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit later and reconcile any press activity.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missed_press_cyc", cyc, e.cyc);
    end
    if (press !== '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_press", 32'(press), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("press_cyc", cyc, e.cyc);
        chk("press_vec", 32'(press), 32'(e.vec));
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int p;

    // Asynchronous reset between clock edges.
    #12;
    rst = 1'b1;
    #1;
    chk("rst_btn_n_out", 32'(btn_n_out), 32'h1F);
    chk("rst_press", 32'(press), 32'h0);
    chk("rst_design_reset", 32'(design_reset), 32'h1);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_dr_cycle1", 32'(design_reset), 32'h1);
    tick();
    chk("rel_dr_cycle2", 32'(design_reset), 32'h0);

    // Clean press and release on new_game.
    btn_n_in[2] = 1'b0;
    expect_press(cyc + LAT, 5'b00100);
    ticks(LAT - 1);
    chk("clean_lvl_before", 32'(btn_n_out[2]), 32'h1);
    tick();
    chk("clean_lvl_fall", 32'(btn_n_out[2]), 32'h0);
    tick();
    chk("clean_press_one_cycle", 32'(press), 32'h0);
    ticks(3);
    btn_n_in[2] = 1'b1;
    ticks(LAT - 1);
    chk("clean_lvl_held", 32'(btn_n_out[2]), 32'h0);
    tick();
    chk("clean_lvl_rise", 32'(btn_n_out[2]), 32'h1);
    ticks(4);
    chk("clean_q_empty", 32'(exp_q.size()), 32'd0);

    // Bounce on pause: 6 low, 1 high, then held low.
    btn_n_in[1] = 1'b0;
    ticks(6);
    btn_n_in[1] = 1'b1;
    tick();
    btn_n_in[1] = 1'b0;
    expect_press(cyc + LAT, 5'b00010);
    ticks(6);
    chk("bounce_lvl_unchanged", 32'(btn_n_out), 32'h1F);
    ticks(LAT - 6);
    chk("bounce_lvl_fall", 32'(btn_n_out[1]), 32'h0);
    btn_n_in[1] = 1'b1;
    ticks(LAT + 2);
    chk("bounce_q_empty", 32'(exp_q.size()), 32'd0);
    chk("bounce_lvl_released", 32'(btn_n_out[1]), 32'h1);

    // External reset drives design_reset.
    btn_n_in[0] = 1'b0;
    expect_press(cyc + LAT, 5'b00001);
    ticks(LAT - 1);
    chk("ext_lvl_before", 32'(btn_n_out[0]), 32'h1);
    tick();
    chk("ext_lvl_fall", 32'(btn_n_out[0]), 32'h0);
    chk("ext_dr_still_low", 32'(design_reset), 32'h0);
    tick();
    chk("ext_dr_plus1", 32'(design_reset), 32'h0);
    tick();
    chk("ext_dr_plus2", 32'(design_reset), 32'h1);
    ticks(3);
    btn_n_in[0] = 1'b1;
    ticks(LAT + 1);
    chk("ext_dr_rel_11", 32'(design_reset), 32'h1);
    tick();
    chk("ext_dr_rel_12", 32'(design_reset), 32'h0);
    chk("ext_q_empty", 32'(exp_q.size()), 32'd0);

    // Simultaneous down+up, then hold up for the repeat window.
    btn_n_in[3] = 1'b0;
    btn_n_in[4] = 1'b0;
    p = cyc + LAT;
    expect_press(p, 5'b11000);
`ifdef SQUASH_AUTOREPEAT_EN
    expect_press(p + 20, 5'b10000);
    expect_press(p + 25, 5'b10000);
    expect_press(p + 30, 5'b10000);
    expect_press(p + 35, 5'b10000);
`endif
    ticks(LAT);
    chk("simul_lvl", 32'(btn_n_out[4:3]), 32'h0);
    btn_n_in[3] = 1'b1;
    ticks(29);
    chk("hold_up_lvl", 32'(btn_n_out[4]), 32'h0);
    btn_n_in[4] = 1'b1;
    ticks(LAT + 15);
    chk("repeat_q_empty", 32'(exp_q.size()), 32'd0);
    chk("repeat_lvl_released", 32'(btn_n_out), 32'h1F);

    // Reset in the middle of a held press.
    btn_n_in[2] = 1'b0;
    expect_press(cyc + LAT, 5'b00100);
    ticks(LAT + 2);
    chk("mid_lvl_low", 32'(btn_n_out[2]), 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_btn_n_out", 32'(btn_n_out), 32'h1F);
    chk("mid_rst_dr", 32'(design_reset), 32'h1);
    btn_n_in[2] = 1'b1;
    tick();
    rst = 1'b0;
    ticks(2);
    chk("mid_dr_released", 32'(design_reset), 32'h0);
    ticks(LAT + 2);
    chk("mid_lvl_stays_high", 32'(btn_n_out), 32'h1F);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/squash_input_conditioner.md
# squash_input_conditioner

Input conditioning stage directly upstream of the Solo Squash top-level wrapper. Takes the five raw active-low button/GPIO inputs (ext_reset_n, pause_n, new_game_n, down_key_n, up_key_n) and produces glitch-free outputs for the wrapper's `io_in[4:0]`. Per channel: multi-stage synchronisation, debouncing and one-cycle press pulses. Also emits a reset with asynchronous assertion and synchronous deassertion, combining `rst` with the debounced external reset.

## Interface
- `N_BTN`, 5: number of channels; index 0 = ext_reset_n, 1 = pause_n, 2 = new_game_n, 3 = down_key_n, 4 = up_key_n.
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_BITS`, 16: debounce counter width; `DB_MAX = 2**DEBOUNCE_BITS-1`.
- `REPEAT_DELAY`, 8_000_000: cycles from press to first auto-repeat pulse (used only with autorepeat).
- `REPEAT_PERIOD`, 2_000_000: cycles between subsequent repeat pulses (used only with autorepeat).
- `clk`  in  1  single clock for the block (mux-issued design clock).
- `rst`  in  1  asynchronous, active-high reset.
- `btn_n_in`  in  N_BTN  raw active-low pad inputs, asynchronous, may bounce.
- `btn_n_out`  out  N_BTN  debounced active-low levels; feeds wrapper `io_in[4:0]`.
- `press`  out  N_BTN  one-cycle pulse per debounced press, plus repeat pulses when enabled.
- `design_reset`  out  1  `rst` OR debounced ext reset; asynchronous assert on `rst`, synchronous deassert.

## Operation
- **Synchroniser.** Each channel passes through a `SYNC_STAGES` flop chain. Output `syn[i]`. Reset value 1 (released).
- **Debounce, per channel.** State register `S[i]` (reset 1) and counter `cnt[i]` (reset 0).
  - `syn != S`: if `cnt == DB_MAX`, then `S <= syn` and `cnt <= 0`; otherwise `cnt <= cnt + 1`.
  - `syn == S`: `cnt <= 0`. Any bounce shorter than `DB_MAX+1` samples is discarded.
  - `btn_n_out = S`, registered with no combinational path from the input.
- **Press pulse.** `press[i]` is registered. It is 1 for exactly one cycle, in the cycle immediately after the edge where `S[i]` goes 1→0. A release (0→1) produces no pulse.
- **Reset generator.** Two flops `r1`, `r2`, asynchronously set by `rst`. Otherwise `r1 <= ~S[0]` and `r2 <= r1`. `design_reset = r2`.
- **Simultaneous transitions.** Channels are fully independent; transitions on several channels in the same cycle are all honoured. `press[0]` still pulses when ext reset is pressed.
- **Reset mid-operation.** All state returns to reset values immediately: `btn_n_out` = all 1, `press` = 0, `design_reset` = 1, counters cleared.
- **Counter width.** `cnt` never exceeds `DB_MAX`; there is no wrap.

## Timing
- Raw edge held stable to a `btn_n_out` change: `SYNC_STAGES + DB_MAX + 1` cycles.
- `press` rises in the same cycle that `btn_n_out` goes low.
- Debounced ext reset low to `design_reset` high: 2 cycles. Debounced release to `design_reset` low: 2 cycles.
- `rst` falling edge with `S[0]=1` to `design_reset` low: 2 cycles.
- `rst` rising edge to all outputs at reset values: asynchronous, no clock edge needed.

## Configuration
- Macro `SQUASH_AUTOREPEAT_EN`.
- **Defined.** Channels 3 and 4 (down/up) add a repeat counter per channel, reset 0 and cleared whenever `S=1`.
  - While `S=0`, `press` pulses again `REPEAT_DELAY` cycles after the initial pulse.
  - It then pulses every `REPEAT_PERIOD` cycles until release.
  - On release, the repeat counter clears within one cycle and no further pulses occur.
- **Undefined.** No repeat logic is synthesised. `press` fires only on the 1→0 debounced edge for every channel. `REPEAT_*` parameters are ignored.

## Structure
- **Shared package `squash_pkg`:**
  - channel index constants `BTN_EXT_RESET=0`, `BTN_PAUSE=1`, `BTN_NEW_GAME=2`, `BTN_DOWN=3`, `BTN_UP=4`
  - `N_BTN`
  - default debounce and repeat constants
- **Sub-module `debounce_channel`:** one instance per channel (synchroniser + counter + `S` + press). It carries a parameter enabling repeat, set only for channels 3 and 4 when `SQUASH_AUTOREPEAT_EN` is defined.
- **Top level:** instantiates the channels via generate and contains the reset generator.

## Test plan
Bench parameters: `SYNC_STAGES=2`, `DEBOUNCE_BITS=3` (`DB_MAX=7`), `REPEAT_DELAY=20`, `REPEAT_PERIOD=5`.

- **Reset values.** Assert `rst` mid-clock → `btn_n_out=5'h1F`, `press=0`, `design_reset=1` with no clock edge. Release `rst` with inputs high → `design_reset=0` after 2 cycles.
- **Clean press.** Drive `btn_n_in[2]` low and hold → `btn_n_out[2]` falls after 10 cycles, `press[2]` high for exactly 1 cycle. Release → `btn_n_out[2]` rises 10 cycles later, no pulse.
- **Bounce rejection.** `btn_n_in[1]` toggles low for 6 cycles, high for 1, low for 6 → no output change. Then hold low 8+ cycles → single press.
- **External reset.** Hold `btn_n_in[0]` low → `btn_n_out[0]` falls at cycle 10 and `design_reset` rises 2 cycles later. Release → `design_reset` falls 12 cycles after release.
- **Simultaneous.** `btn_n_in[3]` and `btn_n_in[4]` fall in the same cycle → both `press` bits pulse in the same cycle.
- **Autorepeat (macro defined).** Hold `btn_n_in[4]` low 40 cycles after its debounced press → `press[4]` pulses at +0, +20, +25, +30, +35 cycles. `press[3]` stays 0. Without the macro, only the +0 pulse occurs.
